// File: rtl/qracc_seq_ctrl_if.sv
// Request/response bundle between the system bus and the QR CIM sequencer.
// slave is the sequencer side, master is the bus/requester side.
interface qracc_seq_ctrl_if #(
  parameter int IN_BITS   = 5,
  parameter int IN_ELEMS  = 128,
  parameter int OUT_BITS  = 4,
  parameter int OUT_ELEMS = 32
);
  localparam int AW = $clog2(IN_ELEMS);

  logic                          cfg_binary;
  logic [IN_ELEMS*IN_BITS-1:0]   mac_data_i;
  logic                          mac_valid_i;
  logic                          ready_o;
  logic                          valid_o;
  logic [OUT_ELEMS*OUT_BITS-1:0] mac_data_o;

  logic                          rq_valid_i;
  logic                          rq_wr_i;
  logic [AW-1:0]                 addr_i;
  logic [OUT_ELEMS-1:0]          wr_data_i;
  logic                          rq_ready_o;
  logic                          rd_valid_o;
  logic [OUT_ELEMS-1:0]          rd_data_o;

  modport slave (
    input  cfg_binary, mac_data_i, mac_valid_i, rq_valid_i, rq_wr_i, addr_i, wr_data_i,
    output ready_o, valid_o, mac_data_o, rq_ready_o, rd_valid_o, rd_data_o
  );

  modport master (
    output cfg_binary, mac_data_i, mac_valid_i, rq_valid_i, rq_wr_i, addr_i, wr_data_i,
    input  ready_o, valid_o, mac_data_o, rq_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/qracc_seq_ctrl.sv
// Sequencer for the QR charge-domain CIM SRAM macro: single-row SRAM write/read
// and bit-serial signed MAC with thermometer-ADC shift-accumulate.
//
// state      | meaning
// IDLE       | accept SRAM request (priority) or MAC request
// WR         | word line + write enable for one cycle
// RD_PCH     | bitline precharge
// RD_SENSE   | word line + sense-amp enable, SA_OUT captured at exit
// RD_CAP     | rd_data_o valid, rd_valid_o pulse
// MAC_RST    | reset phase for current input bit
// MAC_EVAL   | evaluate phase, ADC sampled and accumulated at exit
// MAC_OUT    | mac_data_o valid, valid_o pulse
module qracc_seq_ctrl #(
  parameter int IN_BITS   = 5,
  parameter int IN_ELEMS  = 128,
  parameter int OUT_BITS  = 4,
  parameter int OUT_ELEMS = 32,
  parameter int ADC_BITS  = 4
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  qracc_seq_ctrl_if.slave                       bus,
  output logic [IN_ELEMS-1:0]                   WL,
  output logic                                  PCH,
  output logic                                  WRITE,
  output logic [OUT_ELEMS-1:0]                  WR_DATA,
  output logic [OUT_ELEMS-1:0]                  CSEL,
  output logic                                  SAEN,
  input  logic [OUT_ELEMS-1:0]                  SA_OUT,
  output logic [IN_ELEMS-1:0]                   VDR_SEL,
  output logic [IN_ELEMS-1:0]                   VDR_SEL_B,
  output logic [IN_ELEMS-1:0]                   VSS_SEL,
  output logic [IN_ELEMS-1:0]                   VSS_SEL_B,
  output logic [IN_ELEMS-1:0]                   VRST_SEL,
  output logic [IN_ELEMS-1:0]                   VRST_SEL_B,
  output logic                                  NF,
  output logic                                  NFB,
  output logic                                  M2A,
  output logic                                  M2AB,
  output logic                                  R2A,
  output logic                                  R2AB,
  input  logic [((1<<ADC_BITS)-1)*OUT_ELEMS-1:0] ADC_OUT
);
  localparam int AW    = $clog2(IN_ELEMS);
  localparam int C     = (1 << ADC_BITS) - 1;
  localparam int ACC_W = ADC_BITS + IN_BITS + 1;
  localparam int BW    = $clog2(IN_BITS);
  localparam logic [BW-1:0]             B_LAST  = BW'(IN_BITS - 1);
  localparam logic signed [ADC_BITS:0]  P_OFS   = (ADC_BITS+1)'(1 << (ADC_BITS - 1));
  localparam logic signed [ACC_W-1:0]   OUT_MAX = ACC_W'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0]   OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {
    IDLE, WR, RD_PCH, RD_SENSE, RD_CAP, MAC_RST, MAC_EVAL, MAC_OUT
  } state_t;

  state_t                         state_q, state_d;
  logic [AW-1:0]                  addr_q;
  logic [OUT_ELEMS-1:0]           wdata_q;
  logic [OUT_ELEMS-1:0]           rd_data_q;
  logic [IN_ELEMS*IN_BITS-1:0]    x_q;
  logic                           bin_q;
  logic [BW-1:0]                  b_q;
  logic signed [ACC_W-1:0]        acc_q [OUT_ELEMS];
  logic signed [ACC_W-1:0]        acc_d [OUT_ELEMS];
  logic [OUT_ELEMS*OUT_BITS-1:0]  mac_out_q;
  logic [IN_ELEMS-1:0]            x_bits;
  logic                           in_idle;
  logic                           rq_accept;
  logic                           mac_accept;

  function automatic logic [ADC_BITS-1:0] popcount(input logic [C-1:0] t);
    logic [ADC_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < C; i++) n = n + ADC_BITS'(t[i]);
    return n;
  endfunction

  function automatic logic [OUT_BITS-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> (IN_BITS - 1);
    if (s > OUT_MAX) s = OUT_MAX;
    else if (s < OUT_MIN) s = OUT_MIN;
    return OUT_BITS'(s);
  endfunction

  assign in_idle         = (state_q == IDLE);
  assign rq_accept       = in_idle & bus.rq_valid_i;
  assign mac_accept      = in_idle & ~bus.rq_valid_i & bus.mac_valid_i;

  assign bus.rq_ready_o  = in_idle;
  assign bus.ready_o     = in_idle & ~bus.rq_valid_i;
  assign bus.valid_o     = (state_q == MAC_OUT);
  assign bus.rd_valid_o  = (state_q == RD_CAP);
  assign bus.rd_data_o   = rd_data_q;
  assign bus.mac_data_o  = mac_out_q;

  assign VDR_SEL_B  = ~VDR_SEL;
  assign VSS_SEL_B  = ~VSS_SEL;
  assign VRST_SEL_B = ~VRST_SEL;
  assign NFB        = ~NF;
  assign M2AB       = ~M2A;
  assign R2AB       = ~R2A;

  always_comb begin
    x_bits = '0;
    for (int r = 0; r < IN_ELEMS; r++) x_bits[r] = x_q[r*IN_BITS + int'(b_q)];
  end

  // Signed mode gives the MSB bit-plane negative weight.
  always_comb begin
    logic [ADC_BITS-1:0]     cnt;
    logic signed [ADC_BITS:0] p;
    logic signed [ACC_W-1:0] term;
    logic                    neg;
    cnt  = '0;
    p    = '0;
    term = '0;
    neg  = (b_q == B_LAST) && !bin_q;
    for (int c = 0; c < OUT_ELEMS; c++) begin
      cnt      = popcount(ADC_OUT[c*C +: C]);
      p        = $signed({1'b0, cnt}) - P_OFS;
      term     = ACC_W'(p);
      term     = term <<< b_q;
      acc_d[c] = neg ? (acc_q[c] - term) : (acc_q[c] + term);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    WL       = '0;
    PCH      = 1'b0;
    WRITE    = 1'b0;
    WR_DATA  = '0;
    CSEL     = '0;
    SAEN     = 1'b0;
    VDR_SEL  = '0;
    VSS_SEL  = '0;
    VRST_SEL = '0;
    NF       = 1'b0;
    M2A      = 1'b0;
    R2A      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rq_valid_i)       state_d = bus.rq_wr_i ? WR : RD_PCH;
        else if (bus.mac_valid_i) state_d = MAC_RST;
      end
      WR: begin
        WL[addr_q] = 1'b1;
        WRITE      = 1'b1;
        WR_DATA    = wdata_q;
        CSEL       = '1;
        state_d    = IDLE;
      end
      RD_PCH: begin
        PCH     = 1'b1;
        state_d = RD_SENSE;
      end
      RD_SENSE: begin
        WL[addr_q] = 1'b1;
        SAEN       = 1'b1;
        CSEL       = '1;
        state_d    = RD_CAP;
      end
      RD_CAP:  state_d = IDLE;
      MAC_RST: begin
        VRST_SEL = '1;
        R2A      = 1'b1;
        NF       = 1'b1;
        state_d  = MAC_EVAL;
      end
      MAC_EVAL: begin
        VDR_SEL = x_bits;
        VSS_SEL = ~x_bits;
        M2A     = 1'b1;
        NF      = 1'b1;
        state_d = (b_q == B_LAST) ? MAC_OUT : MAC_RST;
      end
      MAC_OUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result register loads on the edge entering MAC_OUT so data and valid_o align.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      x_q       <= '0;
      bin_q     <= 1'b0;
      b_q       <= '0;
      mac_out_q <= '0;
      for (int c = 0; c < OUT_ELEMS; c++) acc_q[c] <= '0;
    end else begin
      if (rq_accept) begin
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wr_data_i;
      end
      if (mac_accept) begin
        x_q   <= bus.mac_data_i;
        bin_q <= bus.cfg_binary;
        b_q   <= '0;
        for (int c = 0; c < OUT_ELEMS; c++) acc_q[c] <= '0;
      end
      if (state_q == RD_SENSE) rd_data_q <= SA_OUT;
      if (state_q == MAC_EVAL) begin
        b_q <= b_q + 1'b1;
        for (int c = 0; c < OUT_ELEMS; c++) acc_q[c] <= acc_d[c];
        if (b_q == B_LAST) begin
          for (int c = 0; c < OUT_ELEMS; c++)
            mac_out_q[c*OUT_BITS +: OUT_BITS] <= saturate(acc_d[c]);
        end
      end
    end
  end
endmodule

// File: tb/tb_qracc_seq_ctrl.sv
// Directed bench for qracc_seq_ctrl with a behavioural SRAM/ADC macro model.
module tb_qracc_seq_ctrl;
  localparam int IB = 5;
  localparam int IE = 128;
  localparam int OB = 4;
  localparam int OE = 32;
  localparam int AB = 4;
  localparam int C  = 15;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  qracc_seq_ctrl_if #(.IN_BITS(IB), .IN_ELEMS(IE), .OUT_BITS(OB), .OUT_ELEMS(OE)) bus ();

  logic [IE-1:0]   WL, VDR_SEL, VDR_SEL_B, VSS_SEL, VSS_SEL_B, VRST_SEL, VRST_SEL_B;
  logic            PCH, WRITE, SAEN, NF, NFB, M2A, M2AB, R2A, R2AB;
  logic [OE-1:0]   WR_DATA, CSEL, SA_OUT;
  logic [C*OE-1:0] ADC_OUT;

  qracc_seq_ctrl #(.IN_BITS(IB), .IN_ELEMS(IE), .OUT_BITS(OB), .OUT_ELEMS(OE), .ADC_BITS(AB)) dut (
    .clk(clk), .nrst(nrst), .bus(bus),
    .WL(WL), .PCH(PCH), .WRITE(WRITE), .WR_DATA(WR_DATA), .CSEL(CSEL), .SAEN(SAEN), .SA_OUT(SA_OUT),
    .VDR_SEL(VDR_SEL), .VDR_SEL_B(VDR_SEL_B), .VSS_SEL(VSS_SEL), .VSS_SEL_B(VSS_SEL_B),
    .VRST_SEL(VRST_SEL), .VRST_SEL_B(VRST_SEL_B),
    .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB), .R2A(R2A), .R2AB(R2AB),
    .ADC_OUT(ADC_OUT)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int adc_cnt [OE];
  logic [OE-1:0] mem [IE];

  always @(posedge clk)
    if (WRITE) for (int r = 0; r < IE; r++) if (WL[r]) mem[r] <= WR_DATA;

  always_comb begin
    SA_OUT = '0;
    if (SAEN) for (int r = 0; r < IE; r++) if (WL[r]) SA_OUT = mem[r];
  end

  always_comb begin
    ADC_OUT = '0;
    for (int c = 0; c < OE; c++)
      for (int i = 0; i < C; i++)
        if (i < adc_cnt[c]) ADC_OUT[c*C + i] = 1'b1;
  end

  function automatic logic [IE*IB-1:0] make_x(input int k);
    logic [IE*IB-1:0] v;
    for (int r = 0; r < IE; r++) v[r*IB +: IB] = IB'((r*k + 3) % 32);
    return v;
  endfunction

  function automatic logic [IE-1:0] row_bits(input logic [IE*IB-1:0] x, input int b);
    logic [IE-1:0] v;
    for (int r = 0; r < IE; r++) v[r] = x[r*IB + b];
    return v;
  endfunction

  task automatic set_adc_all(input int n);
    for (int c = 0; c < OE; c++) adc_cnt[c] = n;
  endtask

  // Issue one SRAM request from IDLE and observe the following six cycles.
  task automatic do_sram(input logic wr, input logic [6:0] addr, input logic [31:0] data,
                         output int rdv_first, output int rdv_cnt,
                         output logic [IE-1:0] wl1, output logic write1, output logic pch1,
                         output logic saen2, output logic [IE-1:0] wl2);
    bus.rq_valid_i = 1'b1;
    bus.rq_wr_i    = wr;
    bus.addr_i     = addr;
    bus.wr_data_i  = data;
    @(posedge clk); #1;
    bus.rq_valid_i = 1'b0;
    rdv_first = 0;
    rdv_cnt   = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) begin wl1 = WL; write1 = WRITE; pch1 = PCH; end
      if (k == 2) begin saen2 = SAEN; wl2 = WL; end
      if (bus.rd_valid_o) begin rdv_cnt++; if (rdv_first == 0) rdv_first = k; end
    end
  endtask

  // Issue one MAC request, wait for valid_o; lat counts cycles after the accept edge.
  task automatic run_mac(input logic [IE*IB-1:0] x, input logic bin, output int lat,
                         output logic [IE-1:0] vrst1, output logic r2a1,
                         output logic [IE-1:0] vdr2, output logic [IE-1:0] vss2, output logic m2a2);
    int w;
    bus.mac_data_i  = x;
    bus.cfg_binary  = bin;
    bus.mac_valid_i = 1'b1;
    w = 0;
    while (!bus.ready_o && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.mac_valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 40) begin
      if (lat == 1) begin vrst1 = VRST_SEL; r2a1 = R2A; end
      if (lat == 2) begin vdr2 = VDR_SEL; vss2 = VSS_SEL; m2a2 = M2A; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.rq_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_rq_ready got=%b want=1", bus.rq_ready_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
    n_cmp++; if ({bus.valid_o, bus.rd_valid_o} !== 2'b00) begin n_bad++; $display("FAIL reset_valids got=%b want=00", {bus.valid_o, bus.rd_valid_o}); end
    n_cmp++; if (bus.mac_data_o !== '0) begin n_bad++; $display("FAIL reset_mac_data got=%h want=0", bus.mac_data_o); end
    n_cmp++; if (bus.rd_data_o !== '0) begin n_bad++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data_o); end
    n_cmp++; if ({WL, VDR_SEL, VSS_SEL, VRST_SEL} !== '0) begin n_bad++; $display("FAIL reset_selects not all zero"); end
    n_cmp++; if ((VDR_SEL_B & VSS_SEL_B & VRST_SEL_B) !== {IE{1'b1}}) begin n_bad++; $display("FAIL reset_sel_b not all ones"); end
    n_cmp++; if ({PCH, WRITE, SAEN, NF, M2A, R2A, NFB, M2AB, R2AB} !== 9'b000000111) begin n_bad++; $display("FAIL reset_ctrl got=%b want=000000111", {PCH, WRITE, SAEN, NF, M2A, R2A, NFB, M2AB, R2AB}); end
    n_cmp++; if ({CSEL, WR_DATA} !== '0) begin n_bad++; $display("FAIL reset_csel_wrdata got=%h want=0", {CSEL, WR_DATA}); end
    bus.rq_valid_i = 1'b1;
    #1;
    n_cmp++; if ({bus.rq_ready_o, bus.ready_o} !== 2'b10) begin n_bad++; $display("FAIL reset_ready_vs_rq got=%b want=10", {bus.rq_ready_o, bus.ready_o}); end
    bus.rq_valid_i = 1'b0;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int f, n;
    logic [IE-1:0] wl1, wl2;
    logic w1, p1, s2;
    do_sram(1'b1, 7'd5, 32'hA5A5A5A5, f, n, wl1, w1, p1, s2, wl2);
    n_cmp++; if ({w1, wl1} !== {1'b1, IE'(1) << 5}) begin n_bad++; $display("FAIL wr_row5 write=%b wl=%h", w1, wl1); end
    n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL wr_no_rdvalid got=%0d want=0", n); end
    do_sram(1'b1, 7'd126, 32'h12345678, f, n, wl1, w1, p1, s2, wl2);
    n_cmp++; if (wl1 !== (IE'(1) << 126)) begin n_bad++; $display("FAIL wr_row126 wl got=%h", wl1); end
    do_sram(1'b0, 7'd5, 32'h0, f, n, wl1, w1, p1, s2, wl2);
    n_cmp++; if ({p1, s2, wl2} !== {1'b1, 1'b1, IE'(1) << 5}) begin n_bad++; $display("FAIL rd_phases pch=%b saen=%b wl=%h", p1, s2, wl2); end
    n_cmp++; if (f !== 3) begin n_bad++; $display("FAIL rd_latency got=%0d want=3", f); end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL rd_pulses got=%0d want=1", n); end
    n_cmp++; if (bus.rd_data_o !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL rd_data5 got=%h want=a5a5a5a5", bus.rd_data_o); end
    do_sram(1'b0, 7'd126, 32'h0, f, n, wl1, w1, p1, s2, wl2);
    n_cmp++; if (bus.rd_data_o !== 32'h12345678) begin n_bad++; $display("FAIL rd_data126 got=%h want=12345678", bus.rd_data_o); end
  endtask

  task automatic test_priority();
    int rdv, rdyk, lat;
    set_adc_all(12);
    bus.rq_valid_i  = 1'b1;
    bus.rq_wr_i     = 1'b0;
    bus.addr_i      = 7'd5;
    bus.mac_data_i  = make_x(3);
    bus.cfg_binary  = 1'b0;
    bus.mac_valid_i = 1'b1;
    #1;
    n_cmp++; if ({bus.rq_ready_o, bus.ready_o} !== 2'b10) begin n_bad++; $display("FAIL prio_ready got=%b want=10", {bus.rq_ready_o, bus.ready_o}); end
    @(posedge clk); #1;
    bus.rq_valid_i = 1'b0;
    rdv = 0;
    rdyk = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.rd_valid_o && rdv == 0) rdv = k;
      if (bus.ready_o) begin rdyk = k; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (rdv !== 3) begin n_bad++; $display("FAIL prio_rd_latency got=%0d want=3", rdv); end
    n_cmp++; if (rdyk !== 4) begin n_bad++; $display("FAIL prio_mac_ready_cycle got=%0d want=4", rdyk); end
    @(posedge clk); #1;
    bus.mac_valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL prio_mac_latency got=%0d want=11", lat); end
    n_cmp++; if (bus.mac_data_o !== {OE{4'hF}}) begin n_bad++; $display("FAIL prio_mac_data got=%h want=all f", bus.mac_data_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int lat;
    logic [IE-1:0] vrst1, vdr2, vss2, exp_vdr;
    logic r2a1, m2a2;
    logic [IE*IB-1:0] x;
    x = make_x(7);
    exp_vdr = row_bits(x, 0);
    set_adc_all(12);
    run_mac(x, 1'b0, lat, vrst1, r2a1, vdr2, vss2, m2a2);
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL signed_latency got=%0d want=11", lat); end
    n_cmp++; if (bus.mac_data_o !== {OE{4'hF}}) begin n_bad++; $display("FAIL signed_data got=%h want=all f", bus.mac_data_o); end
    n_cmp++; if ({r2a1, vrst1} !== {1'b1, {IE{1'b1}}}) begin n_bad++; $display("FAIL signed_rst_phase r2a=%b vrst=%h", r2a1, vrst1); end
    n_cmp++; if ({m2a2, vdr2, vss2} !== {1'b1, exp_vdr, ~exp_vdr}) begin n_bad++; $display("FAIL signed_eval_rows vdr=%h want=%h", vdr2, exp_vdr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL signed_valid_pulse got=%b want=0", bus.valid_o); end
  endtask

  task automatic test_binary();
    int lat;
    logic [IE-1:0] vrst1, vdr2, vss2;
    logic r2a1, m2a2;
    set_adc_all(12);
    run_mac(make_x(11), 1'b1, lat, vrst1, r2a1, vdr2, vss2, m2a2);
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL binary_latency got=%0d want=11", lat); end
    n_cmp++; if (bus.mac_data_o !== {OE{4'h7}}) begin n_bad++; $display("FAIL binary_sat got=%h want=all 7", bus.mac_data_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_columns();
    int lat;
    logic [IE-1:0] vrst1, vdr2, vss2;
    logic r2a1, m2a2;
    logic [3:0] tab [16];
    logic [OE*OB-1:0] exp_b, exp_s;
    tab = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'hA, 4'hC, 4'hE,
            4'h0, 4'h1, 4'h3, 4'h5, 4'h7, 4'h7, 4'h7, 4'h7};
    for (int c = 0; c < OE; c++) begin
      adc_cnt[c] = c % 16;
      exp_b[c*OB +: OB] = tab[c % 16];
      exp_s[c*OB +: OB] = ((c % 16) > 8) ? 4'hF : 4'h0;
    end
    run_mac(make_x(13), 1'b1, lat, vrst1, r2a1, vdr2, vss2, m2a2);
    n_cmp++; if (bus.mac_data_o !== exp_b) begin n_bad++; $display("FAIL columns_binary got=%h want=%h", bus.mac_data_o, exp_b); end
    @(posedge clk); #1;
    run_mac(make_x(13), 1'b0, lat, vrst1, r2a1, vdr2, vss2, m2a2);
    n_cmp++; if (bus.mac_data_o !== exp_s) begin n_bad++; $display("FAIL columns_signed got=%h want=%h", bus.mac_data_o, exp_s); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc_n, pulses, first, lastv;
    set_adc_all(0);
    bus.mac_data_i  = make_x(5);
    bus.cfg_binary  = 1'b0;
    bus.mac_valid_i = 1'b1;
    acc_n = 0;
    pulses = 0;
    first = -1;
    lastv = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.valid_o) begin pulses++; lastv = cyc; end
      if (bus.ready_o && bus.mac_valid_i) begin if (first < 0) first = cyc; acc_n++; end
      @(posedge clk); #1;
      if (acc_n == 10) bus.mac_valid_i = 1'b0;
    end
    n_cmp++; if (pulses !== 10) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=10", pulses); end
    n_cmp++; if (lastv - first !== 119) begin n_bad++; $display("FAIL b2b_span got=%0d want=119", lastv - first); end
    n_cmp++; if (bus.mac_data_o !== '0) begin n_bad++; $display("FAIL b2b_data got=%h want=0", bus.mac_data_o); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic [IE-1:0] vrst1, vdr2, vss2;
    logic r2a1, m2a2;
    set_adc_all(12);
    run_mac(make_x(9), 1'b1, lat, vrst1, r2a1, vdr2, vss2, m2a2);
    @(posedge clk); #1;
    n_cmp++; if (bus.mac_data_o !== {OE{4'h7}}) begin n_bad++; $display("FAIL rstmid_pre_data got=%h want=all 7", bus.mac_data_o); end
    bus.mac_data_i  = make_x(9);
    bus.cfg_binary  = 1'b0;
    bus.mac_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.mac_valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if ({M2A, NF} !== 2'b11) begin n_bad++; $display("FAIL rstmid_in_eval got=%b want=11", {M2A, NF}); end
    nrst = 1'b0;
    #1;
    n_cmp++; if ({M2A, NF, M2AB, NFB, bus.valid_o} !== 5'b00110) begin n_bad++; $display("FAIL rstmid_ctrl got=%b want=00110", {M2A, NF, M2AB, NFB, bus.valid_o}); end
    n_cmp++; if ({VDR_SEL, ~VSS_SEL_B} !== '0) begin n_bad++; $display("FAIL rstmid_rows not reset"); end
    n_cmp++; if (bus.mac_data_o !== '0) begin n_bad++; $display("FAIL rstmid_data got=%h want=0", bus.mac_data_o); end
    n_cmp++; if (bus.rq_ready_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle got=%b want=1", bus.rq_ready_o); end
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.valid_o) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_no_valid got=%0d want=0", pulses); end
    run_mac(make_x(9), 1'b0, lat, vrst1, r2a1, vdr2, vss2, m2a2);
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL rstmid_next_latency got=%0d want=11", lat); end
    n_cmp++; if (bus.mac_data_o !== {OE{4'hF}}) begin n_bad++; $display("FAIL rstmid_next_data got=%h want=all f", bus.mac_data_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rq_valid_i  = 1'b0;
    bus.rq_wr_i     = 1'b0;
    bus.addr_i      = '0;
    bus.wr_data_i   = '0;
    bus.mac_valid_i = 1'b0;
    bus.mac_data_i  = '0;
    bus.cfg_binary  = 1'b0;
    set_adc_all(0);
    test_reset();
    test_write_read();
    test_priority();
    test_signed();
    test_binary();
    test_columns();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qracc_seq_ctrl.md
# qracc_seq_ctrl
Digital sequencer between the system bus and the QR charge-domain compute-in-memory SRAM macro. It serves single-row SRAM writes and reads through a request/response port. It executes bit-serial signed MAC operations: drives the macro's row-select and phase controls, samples the per-column thermometer ADCs, and shift-accumulates into saturated signed outputs.
## Interface
- inputBits, 5: bits per input element (two's complement, or unsigned in binary mode)
- inputElements, 128: SRAM rows / input vector length
- outputBits, 4: bits per output element
- outputElements, 32: SRAM columns / output vector length
- adcBits, 4: ADC resolution; comparators per column C = 2^adcBits-1
- clk  in  1  single clock, rising edge
- nrst  in  1  reset; asynchronous, active-low
- cfg_binary  in  1  0: inputs signed; 1: inputs unsigned
- mac_data_i  in  inputElements*inputBits  input vector; element r at [r*inputBits +: inputBits]
- mac_valid_i  in  1  MAC request valid
- ready_o  out  1  MAC request can be accepted
- valid_o  out  1  one-cycle pulse: mac_data_o is new
- mac_data_o  out  outputElements*outputBits  result; column c at [c*outputBits +: outputBits]
- rq_valid_i  in  1  SRAM request valid
- rq_wr_i  in  1  1 write, 0 read
- addr_i  in  clog2(inputElements)  row address
- wr_data_i  in  outputElements  write data
- rq_ready_o  out  1  SRAM request accepted when high with rq_valid_i
- rd_valid_o  out  1  one-cycle pulse: rd_data_o is new
- rd_data_o  out  outputElements  read data, held until next read
- WL  out  inputElements  one-hot word line
- PCH  out  1  bitline precharge
- WRITE  out  1  write enable
- WR_DATA  out  outputElements  bitline write data
- CSEL  out  outputElements  column select
- SAEN  out  1  sense-amp enable
- SA_OUT  in  outputElements  sense-amp results
- VDR_SEL, VSS_SEL, VRST_SEL (+ _B complements)  out  inputElements each  per-row drive/ground/reset select
- NF, M2A, R2A (+ NFB, M2AB, R2AB complements)  out  1 each  MAC enable, evaluate phase, reset phase
- ADC_OUT  in  C*outputElements  thermometer; column c at [c*C +: C]
## Operation
- States: IDLE, WR, RD_PCH, RD_SENSE, RD_CAP, MAC_RST, MAC_EVAL, MAC_OUT.
- rq_ready_o = (state==IDLE). ready_o = (state==IDLE) & ~rq_valid_i. SRAM requests take priority over MAC requests.
- Write: on accept, latch addr/data. WR lasts one cycle: WL[addr]=1, WRITE=1, WR_DATA=data, CSEL=all 1s. Then IDLE.
- Read sequence:
  - RD_PCH: PCH=1.
  - RD_SENSE: WL[addr]=1, SAEN=1, CSEL=all 1s.
  - RD_CAP: register SA_OUT into rd_data_o, pulse rd_valid_o.
  - Then IDLE.
- MAC: on accept, latch mac_data_i and cfg_binary, clear the accumulators, set b=0. Then loop b=0..inputBits-1 (LSB first):
  - MAC_RST: VRST_SEL=all 1s, R2A=1, NF=1.
  - MAC_EVAL: for row r, VDR_SEL[r]=x_r[b] and VSS_SEL[r]=~x_r[b]; M2A=1, NF=1.
  - Each column samples ADC_OUT at the edge ending MAC_EVAL.
  - Partial p = popcount(thermometer) - 2^(adcBits-1), range -8..7 by default.
  - acc += p<<b. Exception: b==inputBits-1 with cfg_binary=0 does acc -= p<<b.
- Accumulators are signed, adcBits+inputBits+1 bits wide.
- MAC_OUT: mac_data_o[c] = saturate(acc_c >>> (inputBits-1)) to the signed outputBits range (default -8..7). Pulse valid_o, then IDLE.
- Inactive selects are 0 and every _B output is the inverse of its pair. WL, PCH, WRITE, SAEN, CSEL and WR_DATA are 0 outside their states.
## Timing
- Reset (async): state IDLE; all outputs 0 except the _B complements (all 1s), rq_ready_o=1 and ready_o=~rq_valid_i.
- Reset mid-operation aborts the operation; no rd_valid_o or valid_o pulse is issued.
- Write: busy 1 cycle after the accept edge.
- Read: rd_valid_o is high in the 3rd cycle after the accept edge.
- MAC: 2*inputBits+1 cycles; valid_o is high in cycle 11 after the accept edge by default. mac_data_o holds until the next MAC_OUT.
- Requests presented while not IDLE are held by the requester until the ready signal is seen.
## Test plan
- Write addr 5 = 0xA5A5A5A5, then read addr 5 with the macro model -> rd_data_o=0xA5A5A5A5, one rd_valid_o pulse 3 cycles after accept.
- Read request and mac_valid_i in the same IDLE cycle -> rq_ready_o=1, ready_o=0; MAC accepted only after the read completes.
- ADC forced to count 12 on all columns, cfg_binary=0, any x -> each output = -1 (acc=-4); valid_o exactly 11 cycles after accept.
- Same stimulus with cfg_binary=1 -> acc=124, every output saturates to 7.
- ADC count 0, cfg_binary=0 -> acc=+8, outputs 0. Ten back-to-back MAC requests -> exactly ten valid_o pulses.
- nrst low during MAC_EVAL -> outputs at reset values, no valid_o. The next MAC completes normally.
